// File: rtl/clos_prio_ctrl.sv
// clos_prio_ctrl: round-robin priority pointer generator for the per-output
// arbiters of one Clos node stage. Each output k keeps a pointer that drives
// the node's external priority input. The pointer advances on an accepted
// transfer, on a starvation event, or on a global period tick. Initial
// pointers are staggered so that outputs do not favour the same input in
// lockstep.
module clos_prio_ctrl #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned NumOut      = 4,
  parameter int unsigned StallThresh = 8,
  parameter int unsigned Period      = 0,
  parameter bit          StaggerOn   = 1'b1,
  localparam int unsigned IdxW       = $clog2(NumIn)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic [NumOut-1:0]      req_i,
  input  logic [NumOut-1:0]      gnt_i,
  output logic [NumOut*IdxW-1:0] rr_o,
  output logic [NumOut-1:0]      starve_o,
  output logic                   tick_o
);

  // A disabled threshold or period still needs a 1-bit counter to keep the
  // declarations legal. In that case the counter is held at zero.
  localparam int unsigned SW = (StallThresh == 0) ? 1 : $clog2(StallThresh + 1);
  localparam int unsigned PW = (Period == 0) ? 1 : $clog2(Period + 1);
  localparam logic [SW-1:0] THR_LAST = SW'((StallThresh == 0) ? 0 : StallThresh - 1);
  localparam logic [PW-1:0] PER_LAST = PW'((Period == 0) ? 0 : Period - 1);

  if (NumIn < 2 || (NumIn & (NumIn - 1)) != 0) begin : g_bad_num_in
    $fatal(1, "clos_prio_ctrl: NumIn must be a power of two and >= 2");
  end
  if (NumOut < 1 || (NumOut & (NumOut - 1)) != 0) begin : g_bad_num_out
    $fatal(1, "clos_prio_ctrl: NumOut must be a power of two");
  end

  logic [IdxW-1:0] ptr       [NumOut];
  logic [SW-1:0]   stall_cnt [NumOut];
  logic [PW-1:0]   per_cnt;

  logic [NumOut-1:0] adv;
  logic [NumOut-1:0] starve_hit;
  logic [SW-1:0]     stall_nxt [NumOut];
  logic              tick_fire;
  logic [PW-1:0]     per_nxt;

  // Next-state decode: the period tick, and the per-output handshake and
  // starvation. All advance causes are ORed so that a pointer steps by one.
  always_comb begin
    // NOTE: every combinational output gets a default first, so that no path
    // leaves it unassigned and infers a latch.
    tick_fire = 1'b0;
    per_nxt   = '0;
    if (Period != 0) begin
      tick_fire = (per_cnt == PER_LAST);
      per_nxt   = tick_fire ? '0 : per_cnt + PW'(1);
    end
    for (int k = 0; k < NumOut; k++) begin
      adv[k]        = 1'b0;
      starve_hit[k] = 1'b0;
      stall_nxt[k]  = '0;
      if (req_i[k] && gnt_i[k]) begin
        adv[k] = 1'b1;
      end else if (req_i[k] && StallThresh != 0) begin
        if (stall_cnt[k] == THR_LAST) starve_hit[k] = 1'b1;
        else                          stall_nxt[k]  = stall_cnt[k] + SW'(1);
      end
      adv[k] = adv[k] | starve_hit[k] | tick_fire;
    end
  end

  // State registers. Reset and flush share one path, and flush also acts
  // while the block is disabled.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses only non-blocking assignments, so every
    // register samples values from before this clock edge.
    if (!rst_ni || flush_i) begin
      // NOTE: ptr and stall_cnt are small flop arrays, not RAM. Every entry is
      // reset explicitly in this loop.
      for (int k = 0; k < NumOut; k++) begin
        ptr[k]       <= StaggerOn ? IdxW'(k % NumIn) : '0;
        stall_cnt[k] <= '0;
      end
      per_cnt  <= '0;
      starve_o <= '0;
      tick_o   <= 1'b0;
    end else if (en_i) begin
      for (int k = 0; k < NumOut; k++) begin
        if (adv[k]) ptr[k] <= ptr[k] + IdxW'(1);
        stall_cnt[k] <= stall_nxt[k];
      end
      per_cnt  <= per_nxt;
      starve_o <= starve_hit;
      tick_o   <= tick_fire;
    end else begin
      starve_o <= '0;
      tick_o   <= 1'b0;
    end
  end

  for (genvar k = 0; k < NumOut; k++) begin : g_rr
    assign rr_o[k*IdxW +: IdxW] = ptr[k];
  end

endmodule

// File: tb/tb_clos_prio_ctrl.sv
// Directed bench for clos_prio_ctrl. It uses three instances that share the
// stimulus: default parameters, stagger off, and Period=4.
module tb_clos_prio_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni, en_i, flush_i;
  logic [3:0] req_i, gnt_i;
  logic [7:0] rr_o, rr_ns, rr_per;
  logic [3:0] starve_o, starve_ns, starve_per;
  logic       tick_o, tick_ns, tick_per;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  clos_prio_ctrl u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .req_i(req_i), .gnt_i(gnt_i), .rr_o(rr_o), .starve_o(starve_o), .tick_o(tick_o)
  );

  clos_prio_ctrl #(.StaggerOn(1'b0)) u_dut_ns (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .req_i(req_i), .gnt_i(gnt_i), .rr_o(rr_ns), .starve_o(starve_ns), .tick_o(tick_ns)
  );

  clos_prio_ctrl #(.Period(4)) u_dut_per (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .req_i(req_i), .gnt_i(gnt_i), .rr_o(rr_per), .starve_o(starve_per), .tick_o(tick_per)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge. Inputs are driven, and outputs sampled, 1 ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; en_i = 1'b1; flush_i = 1'b0; req_i = '0; gnt_i = '0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  function automatic int unsigned ptr_of(input logic [7:0] v, input int k);
    return int'(v[k*2 +: 2]);
  endfunction

  initial begin
    // Reset values: staggered {3,2,1,0} packed as 8'hE4, or all zero.
    do_reset();
    check("rst_rr_stagger", rr_o, 8'hE4);
    check("rst_starve", starve_o, 4'h0);
    check("rst_tick", tick_o, 1'b0);
    check("rst_rr_nostagger", rr_ns, 8'h00);
    check("rst_tick_per", tick_per, 1'b0);

    // Five handshakes on output 0: pointer 1,2,3,0,1. The other outputs hold.
    req_i = 4'b0001; gnt_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hs_rr0_%0d", i), ptr_of(rr_o, 0), (i + 1) % 4);
      check($sformatf("hs_others_%0d", i), rr_o[7:2], 6'b11_10_01);
    end
    req_i = '0; gnt_i = '0;

    // Output 1 stalls. A pulse follows the 8th stalled cycle, then another
    // pulse 8 cycles later.
    do_reset();
    req_i = 4'b0010; gnt_i = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("stall1_quiet_%0d", i), starve_o, 4'h0);
    end
    step();
    check("stall1_pulse1", starve_o, 4'b0010);
    check("stall1_rr1_adv", ptr_of(rr_o, 1), 2);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("stall1_quiet2_%0d", i), starve_o, 4'h0);
    end
    step();
    check("stall1_pulse2", starve_o, 4'b0010);
    check("stall1_rr1_adv2", ptr_of(rr_o, 1), 3);
    req_i = '0;

    // Period=4 with no requests: a tick after the 4th cycle, and every
    // pointer advances by one.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("per_quiet_%0d", i), tick_per, 1'b0);
    end
    step();
    check("per_tick1", tick_per, 1'b1);
    check("per_rr_tick1", rr_per, 8'h39);
    step();
    check("per_tick_pulse_end", tick_per, 1'b0);
    step();
    step();
    // The handshake on output 2 coincides with the second tick. rr2 goes
    // from 3 to 0, a single step.
    req_i = 4'b0100; gnt_i = 4'b0100;
    step();
    check("per_tick2", tick_per, 1'b1);
    check("per_rr_tick_hs", rr_per, 8'h4E);
    req_i = '0; gnt_i = '0;

    // Output 3: 5 stalls, 3 disabled cycles, then 3 more stalls give the pulse.
    do_reset();
    req_i = 4'b1000; gnt_i = 4'b0000;
    for (int i = 0; i < 5; i++) step();
    check("en_pre_starve", starve_o, 4'h0);
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("en_off_starve_%0d", i), starve_o, 4'h0);
      check($sformatf("en_off_rr3_%0d", i), ptr_of(rr_o, 3), 3);
    end
    en_i = 1'b1;
    step();
    step();
    check("en_resume_quiet", starve_o, 4'h0);
    step();
    check("en_resume_pulse", starve_o, 4'b1000);
    check("en_resume_rr3", ptr_of(rr_o, 3), 0);

    // A flush after 5 stalls drops the partial count and restores the
    // pointers. Output 0 handshakes alongside so that a pointer has moved.
    do_reset();
    req_i = 4'b1001; gnt_i = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    check("fl_rr0_moved", ptr_of(rr_o, 0), 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("fl_rr_restored", rr_o, 8'hE4);
    check("fl_starve", starve_o, 4'h0);
    req_i = 4'b1000; gnt_i = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("fl_quiet_%0d", i), starve_o, 4'h0);
    end
    step();
    check("fl_pulse", starve_o, 4'b1000);
    check("fl_rr3", ptr_of(rr_o, 3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
